uart_qsys_master_0_b2p_adapter: RTL
===================================

# uart_qsys_master_0_b2p_adapter

Channel-to-packet stream adapter on the return path of the UART Qsys master: takes the channel-tagged 8-bit Avalon-ST byte-packet stream coming back from the channel fabric and delivers a plain packet stream (no channel) to the packet-to-transaction layer. Whole packets whose channel matches `ACCEPT_CHANNEL` are forwarded; packets on any other channel are consumed and discarded in their entirety. The block has a registered output stage with a skid buffer for full throughput, and reports framing errors and dropped packets.

## Interface
- `DATA_W`, 8, payload width
- `CHANNEL_W`, 8, channel field width
- `ACCEPT_CHANNEL`, 0, channel value whose packets are forwarded
- `clk`  in  1  single clock
- `reset`  in  1  synchronous, active-high reset
- `in_ready`  out  1  sink ready; registered
- `in_valid`  in  1  input beat valid
- `in_data`  in  DATA_W  input payload
- `in_channel`  in  CHANNEL_W  channel; sampled only on SOP beats
- `in_startofpacket`  in  1  first beat of packet
- `in_endofpacket`  in  1  last beat of packet
- `out_ready`  in  1  downstream ready
- `out_valid`  out  1  output beat valid
- `out_data`  out  DATA_W  output payload
- `out_startofpacket`  out  1  first beat
- `out_endofpacket`  out  1  last beat
- `drop_count`  out  16  dropped-packet counter, saturating at 0xFFFF
- `framing_err`  out  1  one-cycle pulse on protocol violation

## Operation
- An input beat is accepted when `in_valid & in_ready`. Only accepted beats advance the FSM.
- FSM states:
  - IDLE (between packets)
  - PASS (forwarding)
  - DROP (discarding)
- In IDLE, an SOP beat compares `in_channel` with `ACCEPT_CHANNEL`:
  - Match: push the beat, go to PASS.
  - Mismatch: discard the beat, go to DROP.
  - If that beat also carries EOP, the FSM returns to IDLE. A mismatched single-beat packet still increments `drop_count`.
- In IDLE, a non-SOP beat is discarded and `framing_err` pulses. The state stays IDLE.
- In PASS, beats are pushed. On an EOP beat, go to IDLE.
- In DROP, beats are discarded. On an EOP beat, go to IDLE and increment `drop_count`, saturating.
- SOP while in PASS or DROP:
  - `framing_err` pulses.
  - The previous packet is abandoned. No EOP is synthesized.
  - If the abandoned packet was in DROP, `drop_count` increments.
  - The new SOP is evaluated exactly as it would be in IDLE.
- `in_channel` on non-SOP beats is ignored.
- Discarded beats are accepted at full rate and never reach the output.
- Output path:
  - The output register (`out_*`) is backed by a one-entry skid register.
  - A pushed beat goes to the output register if it is empty or being drained (`out_valid & out_ready`). Otherwise it goes to the skid register.
  - When the output register drains and skid is valid, skid moves to output.
- `in_ready` is the registered value of "skid empty next cycle". `in_ready` stays 1 during DROP unless the skid is occupied.
- Output fields are stable while `out_valid & ~out_ready`.

## Timing
- Reset values:
  - `in_ready` 0, then 1 from the first cycle after `reset` deasserts.
  - `out_valid`, `out_startofpacket`, `out_endofpacket`, `framing_err` all 0.
  - `out_data` 0; `drop_count` 0.
  - FSM goes to IDLE; skid is emptied.
- Latency: an accepted matching beat appears on `out_*` in the next cycle when the output register is free.
- Throughput: one beat per cycle with `out_ready` held high.
- Backpressure: when `out_ready` falls, at most one further beat is absorbed by the skid. `in_ready` is low the following cycle.
- No beat is lost or duplicated under any `out_ready` pattern.
- `framing_err` is asserted the cycle after the offending beat is accepted.
- `drop_count` updates in the same cycle as `framing_err`.
- Reset mid-packet: any partial packet in flight and buffered beats are discarded. The next accepted beat is evaluated in IDLE.

## Structure
- Shared package `uart_qsys_st_pkg`:
  - FSM state enum (IDLE/PASS/DROP).
  - `DROP_CNT_W` = 16.
  - Packed beat struct {data, sop, eop}.
- Natural sub-module: `uart_qsys_st_skid_reg`, a generic one-entry skid/pipeline register over the beat struct, with ready/valid on both sides. The FSM, filter and counter stay in the top module.

## Test plan
- Channel-0 packet 0x11,0x22,0x33 with SOP on the first beat and EOP on the last, `out_ready`=1 → identical three beats out with matching SOP/EOP, 1-cycle latency, `drop_count`=0.
- Channel-5 packet of 4 beats followed by a channel-0 packet 0xAA (SOP+EOP) → only 0xAA out, `drop_count`=1, `in_ready` stays 1 throughout.
- Continuous channel-0 stream of 64 bytes, `out_ready` toggled pseudo-randomly → output byte sequence equals input, no loss or duplication, `out_*` stable while stalled.
- Non-SOP beat 0x55 in IDLE → no output, `framing_err` pulses once. Then SOP on channel 0 mid-DROP (channel-3 packet) → `framing_err` pulses, `drop_count`+1, new packet forwarded.
- Seed `drop_count` at 0xFFFE, send three mismatched single-beat packets → `drop_count` saturates at 0xFFFF.
- Assert `reset` for 1 cycle mid-PASS with the skid full → `out_valid`=0 and `in_ready`=0 that cycle. A following channel-0 SOP packet is forwarded cleanly.

Source files
------------

// File: rtl/uart_qsys_st_pkg.sv
// Shared types for the UART Qsys master return-path stream adapter.
// The package holds the filter FSM state encoding and the packed beat carried through the output buffer.
package uart_qsys_st_pkg;

  localparam int DROP_CNT_W  = 16;
  localparam int BEAT_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PASS,
    ST_DROP
  } state_t;

  typedef struct packed {
    logic [BEAT_DATA_W-1:0] data;
    logic                   sop;
    logic                   eop;
  } beat_t;

endpackage

// File: rtl/uart_qsys_st_skid_reg.sv
// One-entry skid buffer in front of a registered output, with ready/valid handshakes on both sides.
// The sink ready is registered, so the skid entry absorbs the one beat that arrives after the output stalls.
module uart_qsys_st_skid_reg
  import uart_qsys_st_pkg::*;
#(
  parameter type T = beat_t
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  input  T     in_beat,
  output logic in_ready,
  output logic out_valid,
  output T     out_beat,
  input  logic out_ready
);

  T     skid_beat;
  logic skid_vld;
  logic rdy_q;
  logic out_vld_q;
  T     out_beat_q;

  logic drain;
  logic out_vld_n;
  logic skid_vld_n;
  logic ld_out_skid;
  logic ld_out_in;
  logic ld_skid;

  // in_valid is qualified by the caller, so it never arrives while the skid entry is occupied.
  always_comb begin
    drain       = ~out_vld_q | out_ready;
    out_vld_n   = out_vld_q;
    skid_vld_n  = skid_vld;
    ld_out_skid = 1'b0;
    ld_out_in   = 1'b0;
    ld_skid     = 1'b0;
    if (skid_vld) begin
      if (drain) begin
        out_vld_n   = 1'b1;
        skid_vld_n  = 1'b0;
        ld_out_skid = 1'b1;
      end
    end else if (in_valid) begin
      if (drain) begin
        out_vld_n = 1'b1;
        ld_out_in = 1'b1;
      end else begin
        skid_vld_n = 1'b1;
        ld_skid    = 1'b1;
      end
    end else if (drain) begin
      out_vld_n = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_vld_q  <= 1'b0;
      skid_vld   <= 1'b0;
      rdy_q      <= 1'b0;
      out_beat_q <= '0;
    end else begin
      out_vld_q <= out_vld_n;
      skid_vld  <= skid_vld_n;
      rdy_q     <= ~skid_vld_n;
      if (ld_out_skid) begin
        out_beat_q <= skid_beat;
      end else if (ld_out_in) begin
        out_beat_q <= in_beat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ld_skid) begin
      skid_beat <= in_beat;
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = out_vld_q;
  assign out_beat  = out_beat_q;

endmodule

// File: rtl/uart_qsys_master_0_b2p_adapter.sv
// Channel-to-packet adapter: forwards whole packets on ACCEPT_CHANNEL, discards every other packet,
// counts dropped packets (saturating) and flags beats that break SOP/EOP framing.
module uart_qsys_master_0_b2p_adapter
  import uart_qsys_st_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int CHANNEL_W      = 8,
  parameter int ACCEPT_CHANNEL = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  in_ready,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_data,
  input  logic [CHANNEL_W-1:0]  in_channel,
  input  logic                  in_startofpacket,
  input  logic                  in_endofpacket,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_startofpacket,
  output logic                  out_endofpacket,
  output logic [DROP_CNT_W-1:0] drop_count,
  output logic                  framing_err
);

  function automatic logic [DROP_CNT_W-1:0] sat_add(input logic [DROP_CNT_W-1:0] cnt,
                                                    input logic [1:0]            inc);
    logic [DROP_CNT_W:0] sum;
    sum = {1'b0, cnt} + {{(DROP_CNT_W-1){1'b0}}, inc};
    return sum[DROP_CNT_W] ? '1 : sum[DROP_CNT_W-1:0];
  endfunction

  state_t                state;
  state_t                state_n;
  logic                  accept;
  logic                  match;
  logic                  push;
  logic                  err_n;
  logic [1:0]            drop_add;
  logic                  err_q;
  logic [DROP_CNT_W-1:0] drop_cnt_q;
  beat_t                 in_beat;
  beat_t                 out_beat;

  assign accept = in_valid & in_ready;
  assign match  = (in_channel == CHANNEL_W'(ACCEPT_CHANNEL));

  // An SOP always restarts evaluation; abandoning a discarded packet still counts it as dropped,
  // so a mismatched single-beat SOP arriving mid-DROP adds two to the counter.
  always_comb begin
    state_n  = state;
    push     = 1'b0;
    err_n    = 1'b0;
    drop_add = 2'd0;
    if (accept) begin
      if (in_startofpacket) begin
        if (state != ST_IDLE) err_n = 1'b1;
        if (state == ST_DROP) drop_add = drop_add + 2'd1;
        if (match) begin
          push    = 1'b1;
          state_n = in_endofpacket ? ST_IDLE : ST_PASS;
        end else begin
          if (in_endofpacket) drop_add = drop_add + 2'd1;
          state_n = in_endofpacket ? ST_IDLE : ST_DROP;
        end
      end else begin
        case (state)
          ST_IDLE: err_n = 1'b1;
          ST_PASS: begin
            push = 1'b1;
            if (in_endofpacket) state_n = ST_IDLE;
          end
          ST_DROP: begin
            if (in_endofpacket) begin
              drop_add = 2'd1;
              state_n  = ST_IDLE;
            end
          end
          default: state_n = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      err_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state      <= state_n;
      err_q      <= err_n;
      drop_cnt_q <= sat_add(drop_cnt_q, drop_add);
    end
  end

  assign in_beat.data = in_data;
  assign in_beat.sop  = in_startofpacket;
  assign in_beat.eop  = in_endofpacket;

  uart_qsys_st_skid_reg #(
    .T(beat_t)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .in_valid (push),
    .in_beat  (in_beat),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_beat (out_beat),
    .out_ready(out_ready)
  );

  assign out_data          = out_beat.data;
  assign out_startofpacket = out_beat.sop;
  assign out_endofpacket   = out_beat.eop;
  assign drop_count        = drop_cnt_q;
  assign framing_err       = err_q;

endmodule
